// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: performs loads/stores as byte transactions on an 8-bit req/ack port.
// Optional misaligned-word trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_mem_inst,
  input  logic              mem_write_en,
  input  logic              is_word,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [3:0][7:0]   read_data_2,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0][7:0]   wbuf;
  logic [3:0][7:0]   lbuf;
  logic [1:0]        cnt;
  logic              wr_q;
  logic              word_q;
  logic              mis_q;
  logic              last;
  logic              misaligned;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_word & (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign last = word_q ? (cnt == 2'd3) : (cnt == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_addr <= '0;
      wbuf      <= '0;
      lbuf      <= '0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      word_q    <= 1'b0;
      mis_q     <= 1'b0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem_inst) begin
            base_addr <= alu_result;
            wbuf      <= read_data_2;
            wr_q      <= mem_write_en;
            word_q    <= is_word;
            cnt       <= '0;
            lbuf      <= '0;
            mis_q     <= misaligned;
            state     <= misaligned ? DONE : REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!wr_q) lbuf[cnt] <= mem_rdata;
            if (last) begin
              state <= DONE;
              // Final byte bypasses lbuf so load_data is ready in DONE.
              if (!wr_q)
                load_data <= word_q ? {mem_rdata, lbuf[2], lbuf[1], lbuf[0]}
                                    : {24'd0, mem_rdata};
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req    = (state == REQ);
  assign mem_we     = wr_q & mem_req;
  assign mem_addr   = base_addr + ADDR_W'(cnt);
  assign mem_wdata  = wbuf[cnt];
  assign load_valid = (state == DONE) & ~wr_q & ~mis_q;
  // Reset must release the pipeline immediately, independent of is_mem_inst.
  assign stall      = is_mem_inst & (state != DONE) & ~rst;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_err = (state == DONE) & mis_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
